// File: rtl/apb_timer.sv
// apb_timer: APB slave holding a 64-bit machine timer. It has an 8-bit prescaler, a 64-bit
// compare register, one-shot or periodic match modes and a sticky match flag that drives
// timer_int.
module apb_timer #(
  parameter int unsigned           ADDR_WIDTH = 32,
  // Only 32 is supported; registers and strobes are laid out for 32-bit words.
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000_1000
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  output logic                  pready,
  output logic                  perr,
  output logic                  timer_int
);

  localparam logic [2:0] IdxMtimeLo = 3'd0;
  localparam logic [2:0] IdxMtimeHi = 3'd1;
  localparam logic [2:0] IdxCmpLo   = 3'd2;
  localparam logic [2:0] IdxCmpHi   = 3'd3;
  localparam logic [2:0] IdxCtrl    = 3'd4;
  localparam logic [2:0] IdxStatus  = 3'd5;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        en_q, en_d;
  logic        periodic_q, periodic_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        match_q, match_d;
  logic        pready_q, pready_d;
  logic        perr_q, perr_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  addr_ok;
  logic [2:0]            reg_idx;
  logic                  access;
  logic                  wr_en;
  logic                  rd_en;
  logic [31:0]           wmask;
  logic                  tick;
  logic                  cmp_eq;
  logic                  cmp_ge;
  logic                  match_set;
  logic                  match_clr;
  logic [63:0]           mtime_adv;

  // Replace strobed bytes of old_val with new_val.
  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // Address decode; the subtraction wraps, so addresses below the base land out of range.
  assign offset  = paddr - BASE_ADDR;
  assign addr_ok = (offset < ADDR_WIDTH'(24)) && (offset[1:0] == 2'b00);
  assign reg_idx = offset[4:2];

  // An access commits once: pready_q blocks a second commit on the completion cycle.
  assign access = psel && penable && !pready_q;
  assign wr_en  = access && pwrite && addr_ok;
  assign rd_en  = access && !pwrite && addr_ok;

  // Expand byte strobes into a bit mask.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{pstb[i]}};
    end
  end

  // Prescaler: one tick every PRESCALE+1 enabled cycles, held at zero while disabled.
  always_comb begin
    tick   = 1'b0;
    pcnt_d = '0;
    if (en_q) begin
      if (pcnt_q == prescale_q) begin
        tick = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end
  end

  assign cmp_eq = (mtime_q == mtimecmp_q);
  assign cmp_ge = (mtime_q >= mtimecmp_q);

  // Counter advance first, then bus writes overlay only the strobed bytes.
  always_comb begin
    mtime_adv = mtime_q;
    if (tick) begin
      mtime_adv = (periodic_q && cmp_eq) ? '0 : mtime_q + 64'd1;
    end
    mtime_d    = mtime_adv;
    mtimecmp_d = mtimecmp_q;
    if (wr_en) begin
      case (reg_idx)
        IdxMtimeLo: mtime_d[31:0]     = merge(mtime_adv[31:0], pdata, wmask);
        IdxMtimeHi: mtime_d[63:32]    = merge(mtime_adv[63:32], pdata, wmask);
        IdxCmpLo:   mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], pdata, wmask);
        IdxCmpHi:   mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], pdata, wmask);
        default: ;
      endcase
    end
  end

  // Control register fields and the MTIME_HI shadow captured on MTIME_LO reads.
  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    prescale_d = prescale_q;
    if (wr_en && (reg_idx == IdxCtrl)) begin
      if (pstb[0]) begin
        en_d       = pdata[0];
        periodic_d = pdata[1];
      end
      if (pstb[1]) begin
        prescale_d = pdata[15:8];
      end
    end
    shadow_d = (rd_en && (reg_idx == IdxMtimeLo)) ? mtime_q[63:32] : shadow_q;
  end

  // Sticky match flag; a set condition beats a simultaneous write-1-to-clear.
  always_comb begin
    match_set = periodic_q ? (tick && cmp_eq) : (en_q && cmp_ge);
    match_clr = wr_en && (reg_idx == IdxStatus) && pstb[0] && pdata[0];
    match_d   = match_set | (match_q & ~match_clr);
    pready_d  = access;
    perr_d    = access && !addr_ok;
  end

  // Read mux; anything other than a valid register reads as zero.
  always_comb begin
    prdata = '0;
    if (addr_ok) begin
      case (reg_idx)
        IdxMtimeLo: prdata = mtime_q[31:0];
        IdxMtimeHi: prdata = shadow_q;
        IdxCmpLo:   prdata = mtimecmp_q[31:0];
        IdxCmpHi:   prdata = mtimecmp_q[63:32];
        IdxCtrl:    prdata = {16'h0, prescale_q, 6'h0, periodic_q, en_q};
        IdxStatus:  prdata = {31'h0, match_q};
        default:    prdata = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      shadow_q   <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      match_q    <= 1'b0;
      pready_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      match_q    <= match_d;
      pready_q   <= pready_d;
      perr_q     <= perr_d;
    end
  end

  assign pready    = pready_q;
  assign perr      = perr_q;
  assign timer_int = match_q;

endmodule
